nonlinear_tile_sched: RTL and testbench
=======================================

# nonlinear_tile_sched

Tile-level scheduler that shares one `nonlinear_tile` instance (Softplus/Exp) between two requesters: the Δ path (Softplus, one 16-element vector per tile) and the Ā discretisation path (Exp, one 16×16 matrix per tile). It accepts one tile at a time from either client and sequences the shared unit. It holds `mode` stable for the whole operation and routes the result back to the owning client. Only one tile is in flight; arbitration is round-robin per tile, so neither path starves during interleaved 256-channel passes.

## Interface
- `DATA_WIDTH`, 16, element width (signed Q4.12)
- `TILE_SIZE`, 16, vector length / matrix dimension
- `TIMEOUT`, 64, watchdog limit in cycles (used only with `NL_SCHED_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sp_valid`  in  1  Softplus tile offered
- `sp_ready`  out  1  Softplus tile accepted this cycle
- `sp_vec`  in  TILE_SIZE×DATA_WIDTH  Softplus operand vector
- `sp_out_valid`  out  1  Softplus result available
- `sp_out_ready`  in  1  Softplus client takes result
- `sp_out_vec`  out  TILE_SIZE×DATA_WIDTH  Softplus result
- `exp_valid` / `exp_ready` / `exp_mat` (TILE_SIZE²×DATA_WIDTH)  Exp operand channel, same rules
- `exp_out_valid` / `exp_out_ready` / `exp_out_mat`  Exp result channel
- `nl_valid_in`  out  1  start pulse to shared unit
- `nl_mode`  out  1  0 = Softplus, 1 = Exp
- `nl_mid_res_vec` / `nl_mid_res_mat`  out  operands to shared unit
- `nl_y_vec` / `nl_y_mat`  in  results from shared unit
- `nl_done_tile`  in  1  tile complete; results valid this cycle
- `busy`  out  1  state ≠ IDLE
- `err_timeout`  out  1  sticky watchdog flag (tied 0 without the macro)

## Operation
- States: IDLE → ISSUE → WAIT → RETURN → IDLE.
- IDLE: the winner is chosen combinationally from `sp_valid`/`exp_valid`. If both are asserted, the priority pointer decides (reset value = Softplus). Only the winner's `*_ready` is driven high. On the handshake, the operand is latched into the operand register, the owner and mode are registered, and the FSM moves to ISSUE.
- ISSUE: `nl_valid_in`=1 for exactly one cycle, then go to WAIT.
- WAIT: `nl_mode` and operands stay held. On `nl_done_tile`, capture `nl_y_vec`/`nl_y_mat` into the result register and go to RETURN. `nl_done_tile` is ignored in any other state.
- RETURN: assert the owner's `*_out_valid`; the result is stable until `*_out_ready`. On the handshake, toggle the priority pointer to the non-owner and go to IDLE.
- The non-owner's `*_ready` and `*_out_valid` are always 0 outside its own grant.
- `nl_mode` changes only in IDLE on acceptance. It is never changed between ISSUE and the end of RETURN.
- No arithmetic on data; all data is passed through bit-exact.
- Reset mid-operation: the FSM returns to IDLE, registers clear, and any in-flight tile is dropped. A late `nl_done_tile` after reset is ignored.

## Timing
- Reset values:
  - `sp_ready`, `exp_ready`, `*_out_valid`, `nl_valid_in`, `busy`, `err_timeout` = 0
  - `nl_mode` = 0
  - operand and result registers = 0
  - priority pointer = Softplus
- Accept at cycle T → `nl_valid_in` at T+1.
- `nl_done_tile` at cycle D → `*_out_valid` at D+1.
- Minimum accept-to-accept spacing = shared-unit latency + 3 cycles with `out_ready` held high.
- `*_ready` depends combinationally on `*_valid` and state. `*_valid` must not depend on `*_ready`.
- `*_out_valid` deasserts in the cycle after the output handshake.

## Configuration
- `NL_SCHED_TIMEOUT_EN` defined:
  - A cycle counter starts at entry to WAIT.
  - If `nl_done_tile` has not arrived after `TIMEOUT` cycles, set `err_timeout` (sticky until `rst`), return to IDLE without asserting `*_out_valid`, and toggle the priority pointer.
- `NL_SCHED_TIMEOUT_EN` undefined: no counter is built, WAIT waits indefinitely, and `err_timeout` is tied to 0.

## Structure
- `nl_sched_pkg`:
  - state enum `nl_sched_state_e`
  - mode constants `NL_MODE_SOFTPLUS`=0, `NL_MODE_EXP`=1
  - owner enum
  - default `DATA_WIDTH`/`TILE_SIZE` localparams
- Sub-module `nl_rr_arbiter2`: a 2-way round-robin grant with a pointer-advance input. All other logic stays flat.

## Test plan
The bench uses a fixed-latency stub of the shared unit (latency 4). Q4.12 values:
- Single Softplus: `sp_vec` all 0x0000 (stub returns 0x0B17) → `nl_valid_in` one cycle after accept with `nl_mode`=0. `sp_out_vec` all 0x0B17 at accept+7; `exp_out_valid` stays 0.
- Single Exp: `exp_mat` all 0x0000 (stub returns 0x1000) → `nl_mode`=1 held through WAIT; `exp_out_mat` all 0x1000.
- Both valid continuously for 8 tiles → grants alternate SP, EXP, SP, … starting with SP; 4 results per client, each matched to its own operands.
- Backpressure: `sp_out_ready`=0 for 10 cycles → `sp_out_valid` and the data stay stable. No new accept occurs while `exp_valid`=1; EXP is accepted the cycle after the SP handshake.
- `rst` pulsed in WAIT → all outputs at reset values the next cycle. A stub `nl_done_tile` 2 cycles later produces no `*_out_valid`.
- With `NL_SCHED_TIMEOUT_EN`, the stub never completes → `err_timeout`=1 at WAIT entry + 64. The FSM returns to IDLE, and the next request is served normally.

Source files
------------

// File: rtl/nonlinear_tile_sched_pkg.sv
// Shared types for the Softplus/Exp tile scheduler.
// Optional watchdog is enabled with NL_SCHED_TIMEOUT_EN.
package nl_sched_pkg;

    localparam int NL_DATA_WIDTH = 16;
    localparam int NL_TILE_SIZE  = 16;

    localparam logic NL_MODE_SOFTPLUS = 1'b0;
    localparam logic NL_MODE_EXP      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } nl_sched_state_e;

    typedef enum logic {
        OWN_SP  = 1'b0,
        OWN_EXP = 1'b1
    } nl_owner_e;

endpackage

// File: rtl/nonlinear_tile_sched_if.sv
// Client and shared-unit channels of the tile scheduler.
// slave = scheduler side, master = clients plus shared unit.
interface nl_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_SIZE  = 16
);
    localparam int VW = TILE_SIZE * DATA_WIDTH;
    localparam int MW = TILE_SIZE * TILE_SIZE * DATA_WIDTH;

    logic          sp_valid;
    logic          sp_ready;
    logic [VW-1:0] sp_vec;
    logic          sp_out_valid;
    logic          sp_out_ready;
    logic [VW-1:0] sp_out_vec;
    logic          exp_valid;
    logic          exp_ready;
    logic [MW-1:0] exp_mat;
    logic          exp_out_valid;
    logic          exp_out_ready;
    logic [MW-1:0] exp_out_mat;
    logic          nl_valid_in;
    logic          nl_mode;
    logic [VW-1:0] nl_mid_res_vec;
    logic [MW-1:0] nl_mid_res_mat;
    logic [VW-1:0] nl_y_vec;
    logic [MW-1:0] nl_y_mat;
    logic          nl_done_tile;

    modport slave (
        input  sp_valid, sp_vec, sp_out_ready,
        input  exp_valid, exp_mat, exp_out_ready,
        input  nl_y_vec, nl_y_mat, nl_done_tile,
        output sp_ready, sp_out_valid, sp_out_vec,
        output exp_ready, exp_out_valid, exp_out_mat,
        output nl_valid_in, nl_mode,
        output nl_mid_res_vec, nl_mid_res_mat
    );

    modport master (
        output sp_valid, sp_vec, sp_out_ready,
        output exp_valid, exp_mat, exp_out_ready,
        output nl_y_vec, nl_y_mat, nl_done_tile,
        input  sp_ready, sp_out_valid, sp_out_vec,
        input  exp_ready, exp_out_valid, exp_out_mat,
        input  nl_valid_in, nl_mode,
        input  nl_mid_res_vec, nl_mid_res_mat
    );

endinterface

// File: rtl/nonlinear_tile_sched_arb.sv
// Two-way round-robin grant; pointer moves to the
// non-owner when the owning tile retires.
module nl_rr_arbiter2
    import nl_sched_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      req_sp_i,
    input  logic      req_exp_i,
    input  logic      adv_i,
    input  nl_owner_e owner_i,
    output logic      gnt_sp_o,
    output logic      gnt_exp_o
);

    nl_owner_e ptr_q;
    nl_owner_e ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            if (owner_i == OWN_SP) ptr_d = OWN_EXP;
            else                   ptr_d = OWN_SP;
        end
    end

    assign gnt_sp_o  = req_sp_i &&
                       (!req_exp_i || ptr_q == OWN_SP);
    assign gnt_exp_o = req_exp_i &&
                       (!req_sp_i || ptr_q == OWN_EXP);

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= OWN_SP;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/nonlinear_tile_sched.sv
// Shares one Softplus/Exp unit between the delta and A-bar paths.
// Define NL_SCHED_TIMEOUT_EN to build the WAIT watchdog.
module nonlinear_tile_sched
    import nl_sched_pkg::*;
#(
    parameter int DATA_WIDTH = NL_DATA_WIDTH,
    parameter int TILE_SIZE  = NL_TILE_SIZE,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    nl_sched_if.slave  bus,
    output logic       busy,
    output logic       err_timeout
);

    localparam int VW = TILE_SIZE * DATA_WIDTH;
    localparam int MW = TILE_SIZE * TILE_SIZE * DATA_WIDTH;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    nl_sched_state_e state_q, state_d;
    nl_owner_e       owner_q, owner_d;
    logic            mode_q, mode_d;
    logic [VW-1:0]   sp_op_q, sp_op_d;
    logic [MW-1:0]   exp_op_q, exp_op_d;
    logic [VW-1:0]   sp_res_q, sp_res_d;
    logic [MW-1:0]   exp_res_q, exp_res_d;
    logic            gnt_sp, gnt_exp, adv;

`ifdef NL_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    nl_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_sp_i  (bus.sp_valid),
        .req_exp_i (bus.exp_valid),
        .adv_i     (adv),
        .owner_i   (owner_q),
        .gnt_sp_o  (gnt_sp),
        .gnt_exp_o (gnt_exp)
    );

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        mode_d            = mode_q;
        sp_op_d           = sp_op_q;
        exp_op_d          = exp_op_q;
        sp_res_d          = sp_res_q;
        exp_res_d         = exp_res_q;
        adv               = 1'b0;
        bus.sp_ready      = 1'b0;
        bus.exp_ready     = 1'b0;
        bus.sp_out_valid  = 1'b0;
        bus.exp_out_valid = 1'b0;
        bus.nl_valid_in   = 1'b0;
`ifdef NL_SCHED_TIMEOUT_EN
        cnt_d             = cnt_q;
        err_d             = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                bus.sp_ready  = gnt_sp;
                bus.exp_ready = gnt_exp;
                unique case (1'b1)
                    gnt_sp: begin
                        owner_d = OWN_SP;
                        mode_d  = NL_MODE_SOFTPLUS;
                        sp_op_d = bus.sp_vec;
                        state_d = ST_ISSUE;
                    end
                    gnt_exp: begin
                        owner_d  = OWN_EXP;
                        mode_d   = NL_MODE_EXP;
                        exp_op_d = bus.exp_mat;
                        state_d  = ST_ISSUE;
                    end
                    default: ;
                endcase
`ifdef NL_SCHED_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ST_ISSUE: begin
                bus.nl_valid_in = 1'b1;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.nl_done_tile) begin
                    if (owner_q == OWN_SP) sp_res_d = bus.nl_y_vec;
                    else                   exp_res_d = bus.nl_y_mat;
                    state_d = ST_RETURN;
                end
`ifdef NL_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Drop the tile silently; the flag records it.
                    err_d   = 1'b1;
                    adv     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RETURN: begin
                bus.sp_out_valid  = (owner_q == OWN_SP);
                bus.exp_out_valid = (owner_q == OWN_EXP);
                if ((owner_q == OWN_SP && bus.sp_out_ready) ||
                    (owner_q == OWN_EXP && bus.exp_out_ready)) begin
                    adv     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_SP;
            mode_q    <= NL_MODE_SOFTPLUS;
            sp_op_q   <= '0;
            exp_op_q  <= '0;
            sp_res_q  <= '0;
            exp_res_q <= '0;
`ifdef NL_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            mode_q    <= mode_d;
            sp_op_q   <= sp_op_d;
            exp_op_q  <= exp_op_d;
            sp_res_q  <= sp_res_d;
            exp_res_q <= exp_res_d;
`ifdef NL_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign busy               = (state_q != ST_IDLE);
    assign bus.nl_mode        = mode_q;
    assign bus.nl_mid_res_vec = sp_op_q;
    assign bus.nl_mid_res_mat = exp_op_q;
    assign bus.sp_out_vec     = sp_res_q;
    assign bus.exp_out_mat    = exp_res_q;

`ifdef NL_SCHED_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nonlinear_tile_sched.sv
// Directed bench for nonlinear_tile_sched with a latency-4 stub
// of the shared unit (done five cycles after its start pulse).
module tb_nonlinear_tile_sched;

    localparam int DW = 16;
    localparam int TS = 16;
    localparam int VW = TS * DW;
    localparam int MW = TS * TS * DW;
    localparam int TO = 64;
    localparam logic [VW-1:0] SP_PAT  = {TS{16'h0B17}};
    localparam logic [MW-1:0] EXP_PAT = {TS*TS{16'h1000}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err_timeout;
    int   nvec = 0;
    int   nerr = 0;

    nl_sched_if #(.DATA_WIDTH(DW), .TILE_SIZE(TS)) bus ();

    nonlinear_tile_sched #(
        .DATA_WIDTH (DW),
        .TILE_SIZE  (TS),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Stub: not reset by rst, so a late done can reach the DUT.
    logic [VW-1:0] stub_vec  = '0;
    logic [MW-1:0] stub_mat  = '0;
    logic          stub_act  = 1'b0;
    logic          stub_hang = 1'b0;
    int            stub_cnt  = 0;

    always @(posedge clk) begin
        if (bus.nl_valid_in && !stub_hang) begin
            stub_act <= 1'b1;
            stub_cnt <= 4;
            stub_vec <= bus.nl_mid_res_vec;
            stub_mat <= bus.nl_mid_res_mat;
        end else if (stub_act) begin
            if (stub_cnt == 0) stub_act <= 1'b0;
            else               stub_cnt <= stub_cnt - 1;
        end
    end

    assign bus.nl_done_tile = stub_act && (stub_cnt == 0);
    assign bus.nl_y_vec     = stub_vec ^ SP_PAT;
    assign bus.nl_y_mat     = stub_mat ^ EXP_PAT;

    function automatic logic [VW-1:0] mk_vec(input int k);
        logic [VW-1:0] v;
        for (int j = 0; j < TS; j++) v[j*DW +: DW] = 16'(k * 256 + j + 1);
        return v;
    endfunction

    function automatic logic [MW-1:0] mk_mat(input int k);
        logic [MW-1:0] m;
        for (int j = 0; j < TS*TS; j++) m[j*DW +: DW] = 16'(k * 16'h0111 + j * 3);
        return m;
    endfunction

    function automatic int first_diff(input logic [MW-1:0] a, input logic [MW-1:0] b);
        for (int i = 0; i < TS*TS; i++)
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int d;
        rst = 1'b1;
        bus.sp_valid = 1'b0;  bus.sp_vec = '0;  bus.sp_out_ready = 1'b1;
        bus.exp_valid = 1'b0; bus.exp_mat = '0; bus.exp_out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        nvec++; if ({busy, err_timeout, bus.nl_valid_in, bus.nl_mode} !== 4'b0000) begin
            nerr++; $display("FAIL reset_ctl: got %b exp 0000", {busy, err_timeout, bus.nl_valid_in, bus.nl_mode}); end
        nvec++; if ({bus.sp_ready, bus.exp_ready, bus.sp_out_valid, bus.exp_out_valid} !== 4'b0000) begin
            nerr++; $display("FAIL reset_hs: got %b exp 0000", {bus.sp_ready, bus.exp_ready, bus.sp_out_valid, bus.exp_out_valid}); end
        nvec++; if (bus.sp_out_vec !== '0 || bus.nl_mid_res_vec !== '0) begin
            nerr++; $display("FAIL reset_vec: got %h / %h exp 0", bus.sp_out_vec, bus.nl_mid_res_vec); end
        d = first_diff(bus.exp_out_mat, '0);
        nvec++; if (d >= 0) begin
            nerr++; $display("FAIL reset_mat: elem %0d got %h exp 0000", d, bus.exp_out_mat[d*DW +: DW]); end
    endtask

    task automatic test_single_sp();
        tick();
        bus.sp_valid = 1'b1; bus.sp_vec = '0;
        #1;
        nvec++; if ({bus.sp_ready, bus.exp_ready} !== 2'b10) begin
            nerr++; $display("FAIL sp_accept: got %b exp 10", {bus.sp_ready, bus.exp_ready}); end
        for (int n = 1; n <= 8; n++) begin
            tick();
            bus.sp_valid = 1'b0;
            #1;
            if (n == 1) begin
                nvec++; if ({bus.nl_valid_in, bus.nl_mode} !== 2'b10) begin
                    nerr++; $display("FAIL sp_issue: got %b exp 10", {bus.nl_valid_in, bus.nl_mode}); end
            end else if (n <= 6) begin
                nvec++; if ({bus.nl_valid_in, bus.sp_out_valid} !== 2'b00) begin
                    nerr++; $display("FAIL sp_wait n=%0d: got %b exp 00", n, {bus.nl_valid_in, bus.sp_out_valid}); end
            end else if (n == 7) begin
                nvec++; if (bus.sp_out_valid !== 1'b1 || bus.sp_out_vec !== SP_PAT) begin
                    nerr++; $display("FAIL sp_result: got %b %h exp 1 %h", bus.sp_out_valid, bus.sp_out_vec, SP_PAT); end
            end else begin
                nvec++; if ({bus.sp_out_valid, busy} !== 2'b00) begin
                    nerr++; $display("FAIL sp_retire: got %b exp 00", {bus.sp_out_valid, busy}); end
            end
            nvec++; if (bus.exp_out_valid !== 1'b0) begin
                nerr++; $display("FAIL sp_no_exp n=%0d: got %b exp 0", n, bus.exp_out_valid); end
        end
    endtask

    task automatic test_single_exp();
        int d;
        tick();
        bus.exp_valid = 1'b1; bus.exp_mat = '0;
        #1;
        nvec++; if ({bus.sp_ready, bus.exp_ready} !== 2'b01) begin
            nerr++; $display("FAIL exp_accept: got %b exp 01", {bus.sp_ready, bus.exp_ready}); end
        for (int n = 1; n <= 7; n++) begin
            tick();
            bus.exp_valid = 1'b0;
            #1;
            if (n <= 6) begin
                nvec++; if ({bus.nl_mode, bus.exp_out_valid} !== 2'b10) begin
                    nerr++; $display("FAIL exp_hold n=%0d: got %b exp 10", n, {bus.nl_mode, bus.exp_out_valid}); end
            end else begin
                d = first_diff(bus.exp_out_mat, EXP_PAT);
                nvec++; if (bus.exp_out_valid !== 1'b1 || d >= 0) begin
                    nerr++; $display("FAIL exp_result: valid %b elem %0d got %h exp 1000", bus.exp_out_valid, d,
                                     bus.exp_out_mat[(d < 0 ? 0 : d)*DW +: DW]); end
            end
            nvec++; if (bus.sp_out_valid !== 1'b0) begin
                nerr++; $display("FAIL exp_no_sp n=%0d: got %b exp 0", n, bus.sp_out_valid); end
        end
        tick();
    endtask

    task automatic test_alternate();
        int spi = 0, exi = 0, spr = 0, exr = 0, ng = 0, cyc = 0, d;
        logic sp_hs = 1'b0, ex_hs = 1'b0;
        int gs[8];
        while ((spr < 4 || exr < 4) && cyc < 150) begin
            tick();
            cyc++;
            if (sp_hs) spi++;
            if (ex_hs) exi++;
            bus.sp_valid  = (spi < 4); bus.sp_vec  = mk_vec(spi);
            bus.exp_valid = (exi < 4); bus.exp_mat = mk_mat(exi);
            #1;
            sp_hs = bus.sp_valid && bus.sp_ready;
            ex_hs = bus.exp_valid && bus.exp_ready;
            if (sp_hs && ng < 8) begin gs[ng] = 0; ng++; end
            if (ex_hs && ng < 8) begin gs[ng] = 1; ng++; end
            if (bus.sp_ready && bus.exp_ready) begin
                nvec++; nerr++; $display("FAIL alt_both_ready: got 11 exp not both");
            end
            if (bus.sp_out_valid) begin
                nvec++; if (bus.sp_out_vec !== (mk_vec(spr) ^ SP_PAT)) begin
                    nerr++; $display("FAIL alt_sp_res %0d: got %h exp %h", spr, bus.sp_out_vec, mk_vec(spr) ^ SP_PAT); end
                spr++;
            end
            if (bus.exp_out_valid) begin
                d = first_diff(bus.exp_out_mat, mk_mat(exr) ^ EXP_PAT);
                nvec++; if (d >= 0) begin
                    nerr++; $display("FAIL alt_exp_res %0d: elem %0d got %h", exr, d, bus.exp_out_mat[d*DW +: DW]); end
                exr++;
            end
        end
        bus.sp_valid = 1'b0; bus.exp_valid = 1'b0;
        nvec++; if (cyc >= 150 || ng != 8) begin
            nerr++; $display("FAIL alt_progress: got %0d grants %0d/%0d results exp 8 4/4", ng, spr, exr); end
        for (int i = 0; i < ng; i++) begin
            nvec++; if (gs[i] != (i % 2)) begin
                nerr++; $display("FAIL alt_order %0d: got %0d exp %0d", i, gs[i], i % 2); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int d;
        logic found = 1'b0;
        tick();
        bus.sp_valid = 1'b1; bus.sp_vec = mk_vec(7); bus.sp_out_ready = 1'b0;
        #1;
        nvec++; if (bus.sp_ready !== 1'b1) begin
            nerr++; $display("FAIL bp_accept: got %b exp 1", bus.sp_ready); end
        tick();
        bus.sp_valid = 1'b0; bus.exp_valid = 1'b1; bus.exp_mat = mk_mat(9);
        for (int n = 2; n <= 18; n++) begin
            tick();
            if (n == 17) bus.sp_out_ready = 1'b1;
            #1;
            if (n >= 7 && n <= 17) begin
                nvec++; if (bus.sp_out_valid !== 1'b1 || bus.sp_out_vec !== (mk_vec(7) ^ SP_PAT)) begin
                    nerr++; $display("FAIL bp_hold n=%0d: got %b %h exp 1 %h", n, bus.sp_out_valid,
                                     bus.sp_out_vec, mk_vec(7) ^ SP_PAT); end
            end
            if (n <= 17) begin
                nvec++; if (bus.exp_ready !== 1'b0) begin
                    nerr++; $display("FAIL bp_no_accept n=%0d: got %b exp 0", n, bus.exp_ready); end
            end else begin
                nvec++; if ({bus.exp_ready, bus.sp_out_valid} !== 2'b10) begin
                    nerr++; $display("FAIL bp_exp_next: got %b exp 10", {bus.exp_ready, bus.sp_out_valid}); end
            end
        end
        tick();
        bus.exp_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.exp_out_valid) begin found = 1'b1; break; end
            tick();
        end
        d = first_diff(bus.exp_out_mat, mk_mat(9) ^ EXP_PAT);
        nvec++; if (!found || d >= 0) begin
            nerr++; $display("FAIL bp_exp_res: valid %b elem %0d", found, d); end
        tick();
    endtask

    task automatic test_reset_mid();
        int d;
        tick();
        bus.exp_valid = 1'b1; bus.exp_mat = mk_mat(3);
        #1;
        nvec++; if (bus.exp_ready !== 1'b1) begin
            nerr++; $display("FAIL rm_accept: got %b exp 1", bus.exp_ready); end
        tick();
        bus.exp_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        nvec++; if ({busy, bus.nl_mode, bus.nl_valid_in, bus.sp_out_valid, bus.exp_out_valid} !== 5'b00000) begin
            nerr++; $display("FAIL rm_ctl: got %b exp 00000",
                             {busy, bus.nl_mode, bus.nl_valid_in, bus.sp_out_valid, bus.exp_out_valid}); end
        d = first_diff(bus.nl_mid_res_mat, '0);
        nvec++; if (d >= 0) begin
            nerr++; $display("FAIL rm_operand: elem %0d got %h exp 0000", d, bus.nl_mid_res_mat[d*DW +: DW]); end
        for (int n = 5; n <= 12; n++) begin
            tick();
            nvec++; if ({bus.sp_out_valid, bus.exp_out_valid, busy} !== 3'b000) begin
                nerr++; $display("FAIL rm_late_done n=%0d: got %b exp 000", n,
                                 {bus.sp_out_valid, bus.exp_out_valid, busy}); end
        end
    endtask

`ifdef NL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int d;
        logic found = 1'b0;
        stub_hang = 1'b1;
        tick();
        bus.sp_valid = 1'b1; bus.sp_vec = mk_vec(5);
        tick();
        bus.sp_valid = 1'b0;
        for (int n = 2; n <= 66; n++) begin
            tick();
            if (n == 65) begin
                nvec++; if ({err_timeout, busy} !== 2'b01) begin
                    nerr++; $display("FAIL to_before: got %b exp 01", {err_timeout, busy}); end
            end
            if (n == 66) begin
                nvec++; if ({err_timeout, busy} !== 2'b10) begin
                    nerr++; $display("FAIL to_fire: got %b exp 10", {err_timeout, busy}); end
            end
            nvec++; if (bus.sp_out_valid !== 1'b0) begin
                nerr++; $display("FAIL to_no_out n=%0d: got %b exp 0", n, bus.sp_out_valid); end
        end
        stub_hang = 1'b0;
        bus.exp_valid = 1'b1; bus.exp_mat = mk_mat(6);
        tick();
        bus.exp_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.exp_out_valid) begin found = 1'b1; break; end
            tick();
        end
        d = first_diff(bus.exp_out_mat, mk_mat(6) ^ EXP_PAT);
        nvec++; if (!found || d >= 0 || err_timeout !== 1'b1) begin
            nerr++; $display("FAIL to_recover: valid %b elem %0d err %b", found, d, err_timeout); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_sp();
        test_single_exp();
        test_alternate();
        test_backpressure();
        test_reset_mid();
`ifdef NL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
